// File: rtl/spi_port_pkg.sv
// Shared definitions for the SPI port sequencer: register-select codes,
// frame field positions and the sequencer FSM encoding.
package spi_port_pkg;

  localparam logic [3:0] REG_LINE   = 4'b1110;
  localparam logic [3:0] REG_PULLUP = 4'b1101;
  localparam logic [3:0] REG_MODE   = 4'b1011;
  localparam logic [3:0] REG_OUTPUT = 4'b0111;
  localparam logic [3:0] REG_NONE   = 4'b1111;

  localparam int FRAME_BITS = 16;
  localparam int HDR_BITS   = 8;
  localparam int RW_BIT     = 15;
  localparam int IDX_MSB    = 14;
  localparam int IDX_LSB    = 12;
  localparam int REG_MSB    = 11;
  localparam int REG_LSB    = 8;
  localparam int DATA_MSB   = 7;
  localparam int DATA_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_HDR,
    ST_RD_SETUP,
    ST_SHIFT_DATA,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_DRAIN
  } state_e;

  function automatic logic regsel_valid(input logic [3:0] rs);
    return rs inside {REG_LINE, REG_PULLUP, REG_MODE, REG_OUTPUT};
  endfunction

endpackage

// File: rtl/spi_port_sequencer_sync.sv
// Multi-stage synchronizer for an asynchronous SPI pin, with rise/fall
// pulses of the synchronized level (one clk wide).
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(d_i);
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_port_sequencer.sv
// SPI-slave front end that decodes 16-bit frames and sequences reads/writes
// on the shared PORT register bus with setup and hold around each strobe.
module spi_port_sequencer
  import spi_port_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int EN_CYCLES   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 cs_n,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 miso_oe,
  output logic [NUM_PORTS-1:0] port_en,
  output logic                 port_rw,
  output logic [3:0]           port_regsel,
  output logic [7:0]           bus_dout,
  output logic                 bus_oe,
  input  logic [7:0]           bus_din,
  output logic                 frame_err
);

  localparam int CNT_W = (EN_CYCLES + 2 > 2) ? $clog2(EN_CYCLES + 2) : 1;

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .clk_i(clk), .rst_i(rst), .d_i(sclk),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk_i(clk), .rst_i(rst), .d_i(cs_n),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  // Same depth as the sclk path so a rise pulse lines up with its data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync_q <= '0;
    else     mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  state_e             state_q, state_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d, shift_nxt;
  logic [CNT_W-1:0]   en_cnt_q, en_cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [3:0]         regsel_q, regsel_d;
  logic               rw_q, rw_d;
  logic [7:0]         wdata_q, wdata_d;
  logic [7:0]         miso_sr_q, miso_sr_d;
  logic               miso_q, miso_d;
  logic               frame_err_q, frame_err_d;
  logic               miso_oe_q;

  logic               hdr_rw;
  logic [2:0]         hdr_idx;
  logic [3:0]         hdr_rs;
  logic               hdr_bad;

  assign shift_nxt = {shift_q[6:0], mosi_s};
  assign hdr_rw    = shift_nxt[RW_BIT-HDR_BITS];
  assign hdr_idx   = shift_nxt[IDX_MSB-HDR_BITS:IDX_LSB-HDR_BITS];
  assign hdr_rs    = shift_nxt[REG_MSB-HDR_BITS:REG_LSB-HDR_BITS];
  assign hdr_bad   = (int'(hdr_idx) >= NUM_PORTS) || !regsel_valid(hdr_rs) ||
                     (!hdr_rw && (hdr_rs == REG_LINE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      en_cnt_q    <= '0;
      idx_q       <= '0;
      regsel_q    <= REG_NONE;
      rw_q        <= 1'b1;
      wdata_q     <= '0;
      miso_sr_q   <= '0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      en_cnt_q    <= en_cnt_d;
      idx_q       <= idx_d;
      regsel_q    <= regsel_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      miso_sr_q   <= miso_sr_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
      miso_oe_q   <= ~cs_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    en_cnt_d    = en_cnt_q;
    idx_d       = idx_q;
    regsel_d    = regsel_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    miso_sr_d   = miso_sr_q;
    miso_d      = miso_q;
    frame_err_d = 1'b0;

    // The read shift register is zero outside a read, so MISO idles low.
    if (sclk_fall && (state_q != ST_IDLE)) begin
      miso_d    = miso_sr_q[7];
      miso_sr_d = {miso_sr_q[6:0], 1'b0};
    end

    unique case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        miso_sr_d = '0;
        // Mode 0: a frame only starts with sclk idling low.
        if (cs_fall && !sclk_s) begin
          state_d   = ST_SHIFT_HDR;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      ST_SHIFT_HDR: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(HDR_BITS - 1)) begin
            idx_d    = hdr_idx;
            regsel_d = hdr_rs;
            rw_d     = hdr_rw;
            en_cnt_d = '0;
            if (hdr_bad) begin
              frame_err_d = 1'b1;
              state_d     = ST_DRAIN;
            end else if (hdr_rw) begin
              state_d = ST_RD_SETUP;
            end else begin
              state_d = ST_SHIFT_DATA;
            end
          end
        end
      end
      ST_RD_SETUP: begin
        en_cnt_d = en_cnt_q + 1'b1;
        // Final (hold) cycle: the registered strobe is still high on the bus.
        if (en_cnt_q == CNT_W'(EN_CYCLES + 1)) begin
          miso_sr_d = bus_din;
          en_cnt_d  = '0;
          state_d   = cs_s ? ST_IDLE : ST_SHIFT_DATA;
        end
      end
      ST_SHIFT_DATA: begin
        if (cs_rise) begin
          state_d = ST_IDLE;
        end else if (sclk_rise) begin
          shift_d   = shift_nxt;
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'(FRAME_BITS - 1)) begin
            if (rw_q) begin
              state_d = ST_DRAIN;
            end else begin
              wdata_d = shift_nxt[DATA_MSB:DATA_LSB];
              state_d = ST_WR_SETUP;
            end
          end
        end
      end
      ST_WR_SETUP: begin
        en_cnt_d = '0;
        state_d  = cs_s ? ST_IDLE : ST_WR_STROBE;
      end
      ST_WR_STROBE: begin
        en_cnt_d = en_cnt_q + 1'b1;
        if (en_cnt_q == CNT_W'(EN_CYCLES - 1)) state_d = ST_WR_HOLD;
      end
      ST_WR_HOLD: begin
        state_d = cs_s ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (cs_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [NUM_PORTS-1:0] sel_onehot;
  logic [NUM_PORTS-1:0] port_en_q, port_en_d;
  logic                 port_rw_q, port_rw_d;
  logic [3:0]           port_regsel_q, port_regsel_d;
  logic [7:0]           bus_dout_q, bus_dout_d;
  logic                 bus_oe_q, bus_oe_d;

  assign sel_onehot = NUM_PORTS'(1) << idx_q;

  // Bus outputs are registered so the strobe and its qualifiers never glitch.
  always_comb begin
    port_en_d     = '0;
    port_rw_d     = 1'b1;
    port_regsel_d = REG_NONE;
    bus_dout_d    = '0;
    bus_oe_d      = 1'b0;
    unique case (state_q)
      ST_RD_SETUP: begin
        port_regsel_d = regsel_q;
        if ((en_cnt_q != '0) && (en_cnt_q <= CNT_W'(EN_CYCLES))) port_en_d = sel_onehot;
      end
      ST_WR_SETUP, ST_WR_STROBE, ST_WR_HOLD: begin
        port_rw_d     = 1'b0;
        port_regsel_d = regsel_q;
        bus_dout_d    = wdata_q;
        bus_oe_d      = 1'b1;
        if (state_q == ST_WR_STROBE) port_en_d = sel_onehot;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_en_q     <= '0;
      port_rw_q     <= 1'b1;
      port_regsel_q <= REG_NONE;
      bus_dout_q    <= '0;
      bus_oe_q      <= 1'b0;
    end else begin
      port_en_q     <= port_en_d;
      port_rw_q     <= port_rw_d;
      port_regsel_q <= port_regsel_d;
      bus_dout_q    <= bus_dout_d;
      bus_oe_q      <= bus_oe_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign port_en     = port_en_q;
  assign port_rw     = port_rw_q;
  assign port_regsel = port_regsel_q;
  assign bus_dout    = bus_dout_q;
  assign bus_oe      = bus_oe_q;
  assign frame_err   = frame_err_q;

endmodule
